// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave responder: controller states, frame
// geometry and the SPI mode the block implements.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam int FRAME_BITS = 8;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  // {CPOL, CPHA}; mode 0 samples on sck rising edges and idles sck low.
  localparam logic [1:0] SPI_MODE = 2'b00;

  typedef logic [FRAME_BITS-1:0] spi_byte_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with single-cycle
// rise/fall strobes derived only from the synchronised value.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: receives MOSI bytes into rx_data_o and answers with bytes
// from a one-deep holding register, substituting IDLE_MISO when it is empty.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int        SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_MISO  = 8'h00
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       sck_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_underrun_o,
  output logic       busy_o
);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_MODE[1])) u_sync_sck (
    .clock (wb_clk_i),
    .reset (wb_rst_i),
    .d     (sck_i),
    .q     (sck_s),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clock (wb_clk_i),
    .reset (wb_rst_i),
    .d     (cs_n_i),
    .q     (cs_s),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clock (wb_clk_i),
    .reset (wb_rst_i),
    .d     (mosi_i),
    .q     (mosi_s),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  // Only edges of sck/cs and the level of mosi drive the datapath.
  assign unused_sync = ^{sck_s, cs_s, mosi_rise, mosi_fall};

  spi_state_e           state_q, state_d;
  logic                 start_frame, end_frame;
  logic [BIT_CNT_W-1:0] bit_cnt;
  spi_byte_t            rx_shift, tx_shift, hold_data, rx_data_q;
  logic                 hold_full, rx_valid_q, tx_underrun_q;
  logic                 in_frame, rx_shift_en, byte_done, tx_shift_en, tx_load;
  logic                 accept, consume;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          end_frame = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A deselect wins over any sck edge seen in the same cycle.
  assign in_frame    = (state_q == ACTIVE) && !cs_rise;
  assign rx_shift_en = in_frame && sck_rise;
  assign byte_done   = rx_shift_en && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
  assign tx_shift_en = in_frame && sck_fall && (bit_cnt != '0);
  assign tx_load     = start_frame || (in_frame && sck_fall && (bit_cnt == '0));
  assign accept      = tx_valid_i && tx_ready_o;
  assign consume     = tx_load && hold_full;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      rx_valid_q    <= byte_done;
      tx_underrun_q <= tx_load && !hold_full;

      if (start_frame || end_frame) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (rx_shift_en) begin
        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
        rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
      end

      if (byte_done) rx_data_q <= {rx_shift[FRAME_BITS-2:0], mosi_s};

      if (tx_load)          tx_shift <= hold_full ? hold_data : IDLE_MISO;
      else if (tx_shift_en) tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
    end
  end

  // A new byte arriving in the same cycle as a reload leaves the register full.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_data <= tx_data_i;
    end else if (consume) begin
      hold_full <= 1'b0;
    end
  end

  assign tx_ready_o    = !hold_full;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = tx_underrun_q;
  assign busy_o        = (state_q == ACTIVE);
  assign miso_oe_o     = (state_q == ACTIVE);
  assign miso_o        = (state_q == ACTIVE) ? tx_shift[FRAME_BITS-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed plus randomized bench: an SPI master model drives frames while a
// queue-based model predicts MISO bytes, received bytes and underruns.
module tb_spi_slave_responder;

  localparam logic [7:0] IDLE_BYTE = 8'h00;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       sck_i, cs_n_i, mosi_i;
  logic       miso_o, miso_oe_o;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, tx_underrun_o, busy_o;

  spi_slave_responder #(.SYNC_STAGES(2), .IDLE_MISO(IDLE_BYTE)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .sck_i         (sck_i),
    .cs_n_i        (cs_n_i),
    .mosi_i        (mosi_i),
    .miso_o        (miso_o),
    .miso_oe_o     (miso_oe_o),
    .tx_data_i     (tx_data_i),
    .tx_valid_i    (tx_valid_i),
    .tx_ready_o    (tx_ready_o),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .tx_underrun_o (tx_underrun_o),
    .busy_o        (busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int         compare_cnt  = 0;
  int         mismatch_cnt = 0;
  int         underrun_cnt = 0;
  int         oe_high_cnt  = 0;
  logic [7:0] feed_q[$];
  logic [7:0] exp_tx[$];
  logic [7:0] rx_got[$];
  logic [7:0] mosi_buf[8];
  logic [7:0] mread[8];
  logic       start_oe;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_cnt++;
    assert (obs === exp) else begin
      mismatch_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One system clock step; also monitors pulses and feeds the holding register.
  task automatic tick();
    @(negedge wb_clk_i);
    if (rx_valid_o) rx_got.push_back(rx_data_o);
    if (tx_underrun_o) underrun_cnt++;
    if (miso_oe_o) oe_high_cnt++;
    if (tx_valid_i) tx_valid_i = 1'b0;
    if (!tx_valid_i && feed_q.size() > 0 && tx_ready_o && !wb_rst_i) begin
      tx_data_i  = feed_q.pop_front();
      tx_valid_i = 1'b1;
    end
  endtask

  // Master drives stop_edges sck edges (0 = all of nbytes); closing drops cs_n
  // together with the final sck fall.
  task automatic applyStimulus(input int nbytes, input int stop_edges, input bit close_frame);
    int total;
    int b;
    total = (stop_edges > 0) ? stop_edges : nbytes * 16;
    for (int i = 0; i < 8; i++) mread[i] = 8'h00;
    cs_n_i = 1'b0;
    mosi_i = mosi_buf[0][7];
    repeat (4) tick();
    start_oe = miso_oe_o && busy_o;
    for (int e = 0; e < total; e++) begin
      b = e / 2;
      if (e % 2 == 0) begin
        mread[b/8][7-(b%8)] = miso_o;
        sck_i = 1'b1;
      end else begin
        sck_i = 1'b0;
        if (close_frame && e == total - 1) cs_n_i = 1'b1;
        else if (b + 1 < nbytes * 8) mosi_i = mosi_buf[(b+1)/8][7-((b+1)%8)];
      end
      repeat (4) tick();
    end
    if (close_frame) begin
      sck_i  = 1'b0;
      cs_n_i = 1'b1;
      mosi_i = 1'b0;
      repeat (6) tick();
    end
  endtask

  task automatic runFrame(input string tag, input int nbytes);
    logic [7:0] want;
    int         exp_under;
    rx_got.delete();
    underrun_cnt = 0;
    exp_under    = 0;
    applyStimulus(nbytes, 0, 1'b1);
    checkOutput({tag, " oe during"}, 32'(start_oe), 32'd1);
    checkOutput({tag, " oe after"}, 32'(miso_oe_o), 32'd0);
    checkOutput({tag, " busy after"}, 32'(busy_o), 32'd0);
    checkOutput({tag, " rx count"}, 32'(rx_got.size()), 32'(nbytes));
    for (int k = 0; k < nbytes; k++) begin
      if (exp_tx.size() > 0) want = exp_tx.pop_front();
      else begin
        want = IDLE_BYTE;
        exp_under++;
      end
      checkOutput($sformatf("%s miso byte%0d", tag, k), 32'(mread[k]), 32'(want));
      if (k < rx_got.size())
        checkOutput($sformatf("%s rx byte%0d", tag, k), 32'(rx_got[k]), 32'(mosi_buf[k]));
    end
    checkOutput({tag, " underruns"}, 32'(underrun_cnt), 32'(exp_under));
  endtask

  task automatic pushTx(input logic [7:0] v);
    feed_q.push_back(v);
    exp_tx.push_back(v);
  endtask

  initial begin
    int nb;
    int nfed;
    wb_rst_i   = 1'b1;
    sck_i      = 1'b0;
    cs_n_i     = 1'b1;
    mosi_i     = 1'b0;
    tx_data_i  = 8'h00;
    tx_valid_i = 1'b0;
    repeat (3) tick();
    checkOutput("reset miso", 32'(miso_o), 32'd0);
    checkOutput("reset miso_oe", 32'(miso_oe_o), 32'd0);
    checkOutput("reset tx_ready", 32'(tx_ready_o), 32'd1);
    checkOutput("reset rx_valid", 32'(rx_valid_o), 32'd0);
    checkOutput("reset underrun", 32'(tx_underrun_o), 32'd0);
    checkOutput("reset busy", 32'(busy_o), 32'd0);
    wb_rst_i = 1'b0;
    repeat (3) tick();

    pushTx(8'hA5);
    repeat (4) tick();
    mosi_buf[0] = 8'h3C;
    runFrame("preload", 1);

    mosi_buf[0] = 8'($urandom);
    runFrame("empty", 1);

    mosi_buf[0] = 8'h01; mosi_buf[1] = 8'h02; mosi_buf[2] = 8'h03;
    pushTx(8'h10); pushTx(8'h20); pushTx(8'h30);
    repeat (4) tick();
    runFrame("b2b", 3);

    rx_got.delete();
    underrun_cnt = 0;
    mosi_buf[0] = 8'hFF;
    applyStimulus(1, 5, 1'b1);
    checkOutput("partial rx count", 32'(rx_got.size()), 32'd0);
    checkOutput("partial underruns", 32'(underrun_cnt), 32'd1);
    checkOutput("between oe", 32'(miso_oe_o), 32'd0);
    mosi_buf[0] = 8'h81;
    runFrame("after partial", 1);

    pushTx(8'h77);
    repeat (4) tick();
    rx_got.delete();
    oe_high_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      sck_i  = ~sck_i;
      mosi_i = 1'($urandom);
      repeat (4) tick();
    end
    sck_i = 1'b0;
    repeat (4) tick();
    checkOutput("idle sck rx count", 32'(rx_got.size()), 32'd0);
    checkOutput("idle sck oe highs", 32'(oe_high_cnt), 32'd0);
    checkOutput("idle sck tx_ready", 32'(tx_ready_o), 32'd0);
    mosi_buf[0] = 8'($urandom);
    runFrame("held byte", 1);

    mosi_buf[0] = 8'hA3;
    applyStimulus(1, 7, 1'b0);
    checkOutput("pre-reset busy", 32'(busy_o), 32'd1);
    wb_rst_i = 1'b1;
    tick();
    checkOutput("midreset miso", 32'(miso_o), 32'd0);
    checkOutput("midreset miso_oe", 32'(miso_oe_o), 32'd0);
    checkOutput("midreset tx_ready", 32'(tx_ready_o), 32'd1);
    checkOutput("midreset rx_valid", 32'(rx_valid_o), 32'd0);
    checkOutput("midreset underrun", 32'(tx_underrun_o), 32'd0);
    checkOutput("midreset busy", 32'(busy_o), 32'd0);
    sck_i  = 1'b0;
    cs_n_i = 1'b1;
    mosi_i = 1'b0;
    repeat (4) tick();
    wb_rst_i = 1'b0;
    repeat (4) tick();
    pushTx(8'h5A);
    repeat (4) tick();
    mosi_buf[0] = 8'($urandom);
    runFrame("post reset", 1);

    for (int it = 0; it < 5; it++) begin
      nb   = int'($urandom_range(1, 3));
      nfed = int'($urandom_range(0, nb));
      for (int k = 0; k < nb; k++) mosi_buf[k] = 8'($urandom);
      for (int k = 0; k < nfed; k++) pushTx(8'($urandom));
      repeat (4) tick();
      runFrame($sformatf("rand%0d", it), nb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule

// File: doc/spi_slave_responder.md
SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser depth for sck_i, mosi_i and cs_n_i (legal values 2..3).
REQ-002 SHALL have parameter IDLE_MISO, default 8'h00, meaning the byte shifted out when no transmit byte is buffered.
REQ-003 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-004 wb_clk_i  in  1  system clock; all logic on its rising edge.
REQ-005 wb_rst_i  in  1  synchronous active-high reset.
REQ-006 sck_i  in  1  SPI serial clock from the external master; asynchronous to wb_clk_i.
REQ-007 cs_n_i  in  1  SPI chip select, active low; asynchronous.
REQ-008 mosi_i  in  1  SPI master-out data; asynchronous.
REQ-009 miso_o  out  1  SPI master-in data.
REQ-010 miso_oe_o  out  1  MISO output enable; high only while the slave is selected.
REQ-011 tx_data_i  in  8  next byte to transmit.
REQ-012 tx_valid_i  in  1  tx_data_i valid.
REQ-013 tx_ready_o  out  1  holding register empty; a byte is accepted when tx_valid_i and tx_ready_o are both high.
REQ-014 rx_data_o  out  8  last fully received byte.
REQ-015 rx_valid_o  out  1  one-cycle pulse: rx_data_o updated.
REQ-016 tx_underrun_o  out  1  one-cycle pulse: IDLE_MISO loaded because the holding register was empty.
REQ-017 busy_o  out  1  high while in state ACTIVE.

Function
REQ-018 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames, with sck_i no faster than wb_clk_i/8.
REQ-019 SHALL pass sck_i, cs_n_i and mosi_i through SYNC_STAGES flops; all edge detection uses the synchronised signals only.
REQ-020 SHALL use two states: IDLE (cs_n high) and ACTIVE (cs_n low).
REQ-021 IDLE->ACTIVE on the synchronised cs_n falling edge: load tx shift register from the holding register if full, otherwise with IDLE_MISO and pulse tx_underrun_o; clear the bit counter.
REQ-022 In ACTIVE, miso_oe_o SHALL be high and miso_o SHALL equal tx shift register bit 7.
REQ-023 On each synchronised sck rising edge, SHALL shift mosi (synchronised) into the rx shift register LSB and increment the 3-bit bit counter.
REQ-024 On the rising edge where the bit counter wraps 7->0, SHALL register the completed byte on rx_data_o and assert rx_valid_o for exactly the following wb_clk_i cycle; no backpressure exists.
REQ-025 On each synchronised sck falling edge with bit counter non-zero, SHALL shift the tx shift register left by one.
REQ-026 On a synchronised sck falling edge with bit counter zero (byte boundary), SHALL reload the tx shift register per REQ-021 rules, giving back-to-back bytes without cs_n deassertion.
REQ-027 Holding register: tx_ready_o high when empty; accept sets full; a reload consumes it; accept and consume in the same cycle SHALL leave it full with the new byte.
REQ-028 tx_ready_o SHALL be independent of cs_n; a byte may be preloaded in IDLE.
REQ-029 ACTIVE->IDLE on synchronised cs_n rising edge, also mid-byte: discard the partial rx byte, no rx_valid_o, clear the bit counter, miso_oe_o low the next cycle; the holding register is preserved.
REQ-030 In IDLE, sck and mosi edges SHALL be ignored and miso_o SHALL be 0.

Reset
REQ-031 While wb_rst_i is high: state IDLE, synchronisers set to sck=0, cs_n=1, mosi=0; shift registers, rx_data_o and bit counter 0; holding register empty.
REQ-032 Reset values: miso_o 0, miso_oe_o 0, tx_ready_o 1, rx_valid_o 0, tx_underrun_o 0, busy_o 0; reset during ACTIVE aborts the transfer exactly as REQ-029.

Structure
REQ-033 SHALL place the state enumeration (IDLE, ACTIVE), the frame width constant (8) and the SPI mode constant in the shared package spi_pkg.
REQ-034 SHALL instantiate one sub-module, spi_sync_edge (parameterised-depth synchroniser plus rise/fall detect), three times.

Verification
REQ-035 Preload 0xA5, cs_n low, master sends 0x3C -> master reads 0xA5; rx_data_o=0x3C with one rx_valid_o pulse; no underrun.
REQ-036 Holding register empty, cs_n low, one byte -> master reads 0x00, tx_underrun_o pulses once.
REQ-037 Three bytes back-to-back (0x01,0x02,0x03 in; 0x10,0x20,0x30 supplied as tx_ready_o rises) -> master reads 0x10,0x20,0x30; three rx_valid_o pulses with 0x01,0x02,0x03.
REQ-038 cs_n deasserted after 5 sck edges, then full byte 0x81 -> no rx_valid_o for the partial byte; next rx_data_o=0x81; miso_oe_o low between frames.
REQ-039 wb_rst_i asserted mid-byte in ACTIVE -> all outputs at reset values next cycle; later frame with preloaded 0x5A transfers correctly.
REQ-040 sck toggled with cs_n high -> no rx_valid_o, miso_oe_o stays 0, holding register unchanged.
